// File: rtl/demux12_buf.sv
// Buffered 1-to-2 demultiplexer: one valid/ready input steered by I_sel into two
// independent FIFOs, each with its own valid/ready output channel.
module demux12_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] I_data,
    input  logic             I_sel,
    input  logic             I_valid,
    output logic             I_ready,
    output logic [WIDTH-1:0] O0_data,
    output logic             O0_valid,
    input  logic             O0_ready,
    output logic [CW-1:0]    O0_count,
    output logic [WIDTH-1:0] O1_data,
    output logic             O1_valid,
    input  logic             O1_ready,
    output logic [CW-1:0]    O1_count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [2][DEPTH];
    logic [PW-1:0]    wr_ptr [2];
    logic [PW-1:0]    rd_ptr [2];
    logic [CW-1:0]    count  [2];
    logic [1:0]       full;
    logic [1:0]       valid;
    logic [1:0]       push;
    logic [1:0]       pop;

    assign full[0]  = (count[0] == CW'(DEPTH));
    assign full[1]  = (count[1] == CW'(DEPTH));
    assign valid[0] = (count[0] != '0);
    assign valid[1] = (count[1] != '0);

    // No full-bypass: acceptance looks only at registered occupancy of the target
    assign I_ready = I_sel ? ~full[1] : ~full[0];

    assign push[0] = I_valid & I_ready & ~I_sel;
    assign push[1] = I_valid & I_ready & I_sel;
    assign pop[0]  = valid[0] & O0_ready;
    assign pop[1]  = valid[1] & O1_ready;

    assign O0_data  = mem[0][rd_ptr[0]];
    assign O1_data  = mem[1][rd_ptr[1]];
    assign O0_valid = valid[0];
    assign O1_valid = valid[1];
    assign O0_count = count[0];
    assign O1_count = count[1];

    // Pointers wrap naturally since DEPTH is a power of two; full/empty come from count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem[k][i] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) begin
                    mem[k][wr_ptr[k]] <= I_data;
                    wr_ptr[k]         <= wr_ptr[k] + 1'b1;
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + 1'b1;
                end
                count[k] <= count[k] + CW'(push[k]) - CW'(pop[k]);
            end
        end
    end

endmodule

// File: tb/tb_demux12_buf.sv
// Directed self-checking bench for demux12_buf: reset, steering, backpressure,
// channel independence, streaming with pointer wrap, and mid-operation reset.
module tb_demux12_buf;

    logic        clk;
    logic        rst;
    logic [31:0] I_data;
    logic        I_sel;
    logic        I_valid;
    logic        I_ready;
    logic [31:0] O0_data;
    logic        O0_valid;
    logic        O0_ready;
    logic [1:0]  O0_count;
    logic [31:0] O1_data;
    logic        O1_valid;
    logic        O1_ready;
    logic [1:0]  O1_count;

    int checks;
    int passes;

    demux12_buf #(.WIDTH(32), .DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .I_data   (I_data),
        .I_sel    (I_sel),
        .I_valid  (I_valid),
        .I_ready  (I_ready),
        .O0_data  (O0_data),
        .O0_valid (O0_valid),
        .O0_ready (O0_ready),
        .O0_count (O0_count),
        .O1_data  (O1_data),
        .O1_valid (O1_valid),
        .O1_ready (O1_ready),
        .O1_count (O1_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic sel, input logic [31:0] data,
                                 input logic r0, input logic r1);
        I_valid  = valid;
        I_sel    = sel;
        I_data   = data;
        O0_ready = r0;
        O1_ready = r1;
        #1;
    endtask

    // Advance to 2 time units past the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " O0_valid"}, 32'(O0_valid), 32'd0);
        checkOutput({tag, " O1_valid"}, 32'(O1_valid), 32'd0);
        checkOutput({tag, " O0_count"}, 32'(O0_count), 32'd0);
        checkOutput({tag, " O1_count"}, 32'(O1_count), 32'd0);
        checkOutput({tag, " O0_data"},  O0_data, 32'd0);
        checkOutput({tag, " O1_data"},  O1_data, 32'd0);
        checkOutput({tag, " I_ready"},  32'(I_ready), 32'd1);
    endtask

    initial begin
        checks   = 0;
        passes   = 0;
        rst      = 1'b0;
        I_valid  = 1'b0;
        I_sel    = 1'b0;
        I_data   = '0;
        O0_ready = 1'b0;
        O1_ready = 1'b0;

        // Reset asserted between edges takes effect without a clock
        #3;
        rst = 1'b1;
        #1;
        checkIdle("reset_async");
        tick();
        rst = 1'b0;
        #1;
        checkIdle("reset_release");

        // Steering
        tick();
        applyStimulus(1'b1, 1'b0, 32'hA5A5_0001, 1'b0, 1'b0);
        checkOutput("steer I_ready", 32'(I_ready), 32'd1);
        tick();
        applyStimulus(1'b1, 1'b1, 32'h5A5A_0002, 1'b0, 1'b0);
        checkOutput("steer O0_data",  O0_data, 32'hA5A5_0001);
        checkOutput("steer O0_valid", 32'(O0_valid), 32'd1);
        checkOutput("steer O0_count", 32'(O0_count), 32'd1);
        checkOutput("steer O1_valid early", 32'(O1_valid), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("steer O1_data",  O1_data, 32'h5A5A_0002);
        checkOutput("steer O1_valid", 32'(O1_valid), 32'd1);
        checkOutput("steer O1_count", 32'(O1_count), 32'd1);
        checkOutput("steer O0_count hold", 32'(O0_count), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("steer drain O0_count", 32'(O0_count), 32'd0);
        checkOutput("steer drain O1_count", 32'(O1_count), 32'd0);

        // Full / backpressure on channel 0
        applyStimulus(1'b1, 1'b0, 32'h1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h2, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h3, 1'b0, 1'b0);
        checkOutput("full O0_count", 32'(O0_count), 32'd2);
        checkOutput("full I_ready", 32'(I_ready), 32'd0);
        checkOutput("full head", O0_data, 32'h1);
        tick();
        checkOutput("full held count", 32'(O0_count), 32'd2);
        applyStimulus(1'b1, 1'b0, 32'h3, 1'b1, 1'b0);
        checkOutput("full pop I_ready", 32'(I_ready), 32'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h3, 1'b0, 1'b0);
        checkOutput("full after pop count", 32'(O0_count), 32'd1);
        checkOutput("full after pop head", O0_data, 32'h2);
        checkOutput("full after pop I_ready", 32'(I_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("full accept count", 32'(O0_count), 32'd2);
        checkOutput("full accept head", O0_data, 32'h2);

        // Independence: channel 0 stays full while channel 1 flows
        applyStimulus(1'b1, 1'b0, 32'h10, 1'b0, 1'b0);
        checkOutput("indep I_ready sel0", 32'(I_ready), 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h10, 1'b0, 1'b0);
        checkOutput("indep I_ready sel1", 32'(I_ready), 32'd1);
        tick();
        applyStimulus(1'b1, 1'b1, 32'h11, 1'b0, 1'b0);
        checkOutput("indep I_ready 2nd", 32'(I_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("indep O1_count", 32'(O1_count), 32'd2);
        checkOutput("indep O1 head0", O1_data, 32'h10);
        checkOutput("indep O0_count", 32'(O0_count), 32'd2);
        tick();
        checkOutput("indep O1 head1", O1_data, 32'h11);
        checkOutput("indep O1_count 1", 32'(O1_count), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("indep O1 drained", 32'(O1_valid), 32'd0);
        checkOutput("indep O0 still full", 32'(O0_count), 32'd2);
        checkOutput("order head 2", O0_data, 32'h2);
        tick();
        checkOutput("order head 3", O0_data, 32'h3);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("order drained", 32'(O0_count), 32'd0);

        // Streaming with both consumers always ready; pointers wrap
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'(i % 2), 32'(i), 1'b1, 1'b1);
            tick();
            if (i % 2 == 0) begin
                checkOutput($sformatf("stream%0d O0_data", i), O0_data, 32'(i));
                checkOutput($sformatf("stream%0d O0_count", i), 32'(O0_count), 32'd1);
                checkOutput($sformatf("stream%0d O1_count", i), 32'(O1_count), 32'd0);
            end else begin
                checkOutput($sformatf("stream%0d O1_data", i), O1_data, 32'(i));
                checkOutput($sformatf("stream%0d O1_count", i), 32'(O1_count), 32'd1);
                checkOutput($sformatf("stream%0d O0_count", i), 32'(O0_count), 32'd0);
            end
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        checkOutput("stream end O0_count", 32'(O0_count), 32'd0);
        checkOutput("stream end O1_count", 32'(O1_count), 32'd0);

        // Reset mid-operation
        applyStimulus(1'b1, 1'b0, 32'hAA, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'hBB, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 32'hCC, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 32'hDD, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("prefill O0_count", 32'(O0_count), 32'd2);
        checkOutput("prefill O1_count", 32'(O1_count), 32'd2);
        rst = 1'b1;
        #1;
        checkIdle("midreset");
        rst = 1'b0;
        #1;
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("post reset O1_data",  O1_data, 32'hFFFF_FFFF);
        checkOutput("post reset O1_count", 32'(O1_count), 32'd1);
        checkOutput("post reset O0_valid", 32'(O0_valid), 32'd0);
        checkOutput("post reset O0_data",  O0_data, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
